// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkg
//  Description : Shared constants and encodings for the 1x3 router datapath:
//                default byte width, header address field, FSM state codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    // Default width of header, payload and parity bytes
    localparam int c_DATA_WIDTH = 8;

    // Header address field, data_in[1:0]
    localparam logic [1:0] c_ADDR_FIFO0   = 2'b00;
    localparam logic [1:0] c_ADDR_FIFO1   = 2'b01;
    localparam logic [1:0] c_ADDR_FIFO2   = 2'b10;
    localparam logic [1:0] c_ADDR_INVALID = 2'b11;

    // State encodings used by fsm_controller, shared for decoding in benches
    typedef enum logic [2:0] {
        S_DECODE_ADDRESS     = 3'd0,
        S_LOAD_FIRST_DATA    = 3'd1,
        S_LOAD_DATA          = 3'd2,
        S_WAIT_TILL_EMPTY    = 3'd3,
        S_FIFO_FULL_STATE    = 3'd4,
        S_LOAD_AFTER_FULL    = 3'd5,
        S_LOAD_PARITY        = 3'd6,
        S_CHECK_PARITY_ERROR = 3'd7
    } router_state_e;

endpackage : router_pkg
`default_nettype wire

// File: rtl/router_parity_chk.sv
`default_nettype none
// ============================================================================
//  Module      : router_parity_chk
//  Description : Running XOR parity over header and payload, capture of the
//                packet parity byte, and the registered parity error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module router_parity_chk
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_detect_addr,
    input  logic                  i_lfd_state,
    input  logic                  i_ld_state,
    input  logic                  i_laf_state,
    input  logic                  i_full_state,
    input  logic                  i_pkt_valid,
    input  logic                  i_fifo_full,
    input  logic                  i_low_pkt_valid,
    input  logic                  i_parity_done,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    input  logic [DATA_WIDTH-1:0] i_header_byte,
    input  logic [DATA_WIDTH-1:0] i_full_byte,
    output logic                  o_err
);

    logic [DATA_WIDTH-1:0] r_int_parity;
    logic [DATA_WIDTH-1:0] r_pkt_parity;
    logic                  r_err;
    logic                  w_pkt_par_from_data;
    logic                  w_pkt_par_from_full;

    // Parity byte arrives directly, or is replayed from the full-byte holder
    assign w_pkt_par_from_data = i_ld_state && !i_pkt_valid && !i_fifo_full;
    assign w_pkt_par_from_full = i_laf_state && i_low_pkt_valid && !i_parity_done;

    // Running XOR of header and payload; the parity byte is never folded in
    always_ff @(posedge clk) begin
        if (rst) begin
            r_int_parity <= '0;
        end else if (i_detect_addr) begin
            r_int_parity <= '0;
        end else if (i_lfd_state) begin
            r_int_parity <= r_int_parity ^ i_header_byte;
        end else if (i_ld_state && i_pkt_valid && !i_full_state) begin
            r_int_parity <= r_int_parity ^ i_data_in;
        end
    end

    // Capture of the parity byte sent by the source
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_parity <= '0;
        end else if (w_pkt_par_from_data) begin
            r_pkt_parity <= i_data_in;
        end else if (w_pkt_par_from_full) begin
            r_pkt_parity <= i_full_byte;
        end else if (i_detect_addr) begin
            r_pkt_parity <= '0;
        end
    end

    // Error flag refreshed every cycle parity_done is high, one cycle behind it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (i_detect_addr) begin
            r_err <= 1'b0;
        end else if (i_parity_done) begin
            r_err <= (r_int_parity != r_pkt_parity);
        end
    end

    assign o_err = r_err;

endmodule : router_parity_chk
`default_nettype wire

// File: rtl/router_reg.sv
`default_nettype none
// ============================================================================
//  Module      : router_reg
//  Description : Router datapath register stage. Latches the header, holds the
//                byte that arrives while the FIFO is full, drives dout and
//                tracks parity status for fsm_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module router_reg
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_pkt_valid,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    input  logic                  i_fifo_full,
    input  logic                  i_detect_addr,
    input  logic                  i_lfd_state,
    input  logic                  i_ld_state,
    input  logic                  i_laf_state,
    input  logic                  i_full_state,
    input  logic                  i_rst_int_reg,
    output logic                  o_parity_done,
    output logic                  o_low_pkt_valid,
    output logic                  o_err,
    output logic [DATA_WIDTH-1:0] o_dout
);

    logic [DATA_WIDTH-1:0] r_header_byte;
    logic [DATA_WIDTH-1:0] r_full_byte;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_low_pkt_valid;
    logic                  r_parity_done;
    logic                  w_parity_done_set;

    // Parity byte seen either directly in LOAD_DATA or replayed after full
    assign w_parity_done_set = (i_ld_state && !i_fifo_full && !i_pkt_valid) ||
                               (i_laf_state && r_low_pkt_valid && !r_parity_done);

    // Header byte captured while the FSM decodes the address
    always_ff @(posedge clk) begin
        if (rst) begin
            r_header_byte <= '0;
        end else if (i_detect_addr && i_pkt_valid) begin
            r_header_byte <= i_data_in;
        end
    end

    // Byte that arrived on the cycle the FIFO filled, replayed later
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full_byte <= '0;
        end else if (i_ld_state && i_fifo_full) begin
            r_full_byte <= i_data_in;
        end
    end

    // Output byte stream toward the destination FIFOs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= '0;
        end else if (i_lfd_state) begin
            r_dout <= r_header_byte;
        end else if (i_ld_state && !i_fifo_full) begin
            r_dout <= i_data_in;
        end else if (i_laf_state) begin
            r_dout <= r_full_byte;
        end
    end

    // pkt_valid dropped during load; setting has priority over clearing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_low_pkt_valid <= 1'b0;
        end else if (i_ld_state && !i_pkt_valid) begin
            r_low_pkt_valid <= 1'b1;
        end else if (i_rst_int_reg) begin
            r_low_pkt_valid <= 1'b0;
        end
    end

    // Parity byte captured; sticky until the next address decode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity_done <= 1'b0;
        end else if (w_parity_done_set) begin
            r_parity_done <= 1'b1;
        end else if (i_detect_addr) begin
            r_parity_done <= 1'b0;
        end
    end

    router_parity_chk #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_chk (
        .clk             (clk),
        .rst             (rst),
        .i_detect_addr   (i_detect_addr),
        .i_lfd_state     (i_lfd_state),
        .i_ld_state      (i_ld_state),
        .i_laf_state     (i_laf_state),
        .i_full_state    (i_full_state),
        .i_pkt_valid     (i_pkt_valid),
        .i_fifo_full     (i_fifo_full),
        .i_low_pkt_valid (r_low_pkt_valid),
        .i_parity_done   (r_parity_done),
        .i_data_in       (i_data_in),
        .i_header_byte   (r_header_byte),
        .i_full_byte     (r_full_byte),
        .o_err           (o_err)
    );

    assign o_parity_done   = r_parity_done;
    assign o_low_pkt_valid = r_low_pkt_valid;
    assign o_dout          = r_dout;

endmodule : router_reg
`default_nettype wire

// File: tb/tb_router_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_router_reg
//  Description : Self-checking bench for router_reg: cycle reference model,
//                byte-stream scoreboard, packet-level parity checks, plus
//                directed packets with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_router_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       fifo_full = 1'b0;
    logic       detect_addr = 1'b0;
    logic       lfd_state = 1'b0;
    logic       ld_state = 1'b0;
    logic       laf_state = 1'b0;
    logic       full_state = 1'b0;
    logic       rst_int_reg = 1'b0;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       err;
    logic [7:0] dout;

    int n_checks = 0;
    int n_errors = 0;

    router_reg #(.DATA_WIDTH(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_pkt_valid     (pkt_valid),
        .i_data_in       (data_in),
        .i_fifo_full     (fifo_full),
        .i_detect_addr   (detect_addr),
        .i_lfd_state     (lfd_state),
        .i_ld_state      (ld_state),
        .i_laf_state     (laf_state),
        .i_full_state    (full_state),
        .i_rst_int_reg   (rst_int_reg),
        .o_parity_done   (parity_done),
        .o_low_pkt_valid (low_pkt_valid),
        .o_err           (err),
        .o_dout          (dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model (register-level rules) ----------------
    typedef struct packed {
        logic [7:0] hdr;
        logic [7:0] fb;
        logic [7:0] dout;
        logic [7:0] ip;
        logic [7:0] pp;
        logic       lpv;
        logic       pd;
        logic       err;
    } mstate_t;

    mstate_t m = '0;
    bit      model_ok = 1'b0;

    function automatic mstate_t step(input mstate_t s);
        mstate_t n = s;
        if (rst) return '0;
        if (detect_addr && pkt_valid) n.hdr = data_in;
        if (ld_state && fifo_full) n.fb = data_in;
        if (lfd_state) n.dout = s.hdr;
        else if (ld_state && !fifo_full) n.dout = data_in;
        else if (laf_state) n.dout = s.fb;
        if (detect_addr) n.ip = 8'h00;
        else if (lfd_state) n.ip = s.ip ^ s.hdr;
        else if (ld_state && pkt_valid && !full_state) n.ip = s.ip ^ data_in;
        if (ld_state && !pkt_valid && !fifo_full) n.pp = data_in;
        else if (laf_state && s.lpv && !s.pd) n.pp = s.fb;
        else if (detect_addr) n.pp = 8'h00;
        if (ld_state && !pkt_valid) n.lpv = 1'b1;
        else if (rst_int_reg) n.lpv = 1'b0;
        if ((ld_state && !fifo_full && !pkt_valid) || (laf_state && s.lpv && !s.pd)) n.pd = 1'b1;
        else if (detect_addr) n.pd = 1'b0;
        if (detect_addr) n.err = 1'b0;
        else if (s.pd) n.err = (s.ip != s.pp);
        return n;
    endfunction

    always @(posedge clk) begin
        m <= step(m);
        if (rst) model_ok <= 1'b1;
    end

    // Every-cycle compare of all outputs against the model
    always @(negedge clk) begin
        if (model_ok) begin
            chk("model_dout", dout, m.dout);
            chk("model_parity_done", {7'b0, parity_done}, {7'b0, m.pd});
            chk("model_low_pkt_valid", {7'b0, low_pkt_valid}, {7'b0, m.lpv});
            chk("model_err", {7'b0, err}, {7'b0, m.err});
        end
    end

    // ---------------- byte-stream scoreboard ----------------
    logic [7:0] exp_q[$];
    logic       wr_seen = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            wr_seen <= 1'b0;
        end else begin
            wr_seen <= lfd_state || (ld_state && !fifo_full) || laf_state;
        end
    end

    always @(negedge clk) begin
        if (wr_seen && exp_q.size() > 0) chk("stream_dout", dout, exp_q.pop_front());
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic r, input logic da, input logic lfd, input logic ld,
                         input logic laf, input logic fs, input logic rir,
                         input logic pv, input logic ff, input logic [7:0] d);
        rst = r; detect_addr = da; lfd_state = lfd; ld_state = ld; laf_state = laf;
        full_state = fs; rst_int_reg = rir; pkt_valid = pv; fifo_full = ff; data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();  drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00); endtask
    task automatic idle();      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00); endtask
    task automatic da(input logic [7:0] d);  drive(0, 1, 0, 0, 0, 0, 0, 1, 0, d); endtask
    task automatic lfd(input logic [7:0] d); drive(0, 0, 1, 0, 0, 0, 0, 1, 0, d); endtask
    task automatic ldb(input logic [7:0] d, input logic pv, input logic ff);
        drive(0, 0, 0, 1, 0, 0, 0, pv, ff, d);
    endtask
    task automatic fsc(input logic pv); drive(0, 0, 0, 0, 0, 1, 0, pv, 1, 8'h5A); endtask
    task automatic laf(input logic pv); drive(0, 0, 0, 0, 1, 0, 0, pv, 0, 8'hA5); endtask
    task automatic rir();  drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00); endtask

    task automatic rand_pkt(input bit allow_abort);
        int         len;
        int         abort_at;
        logic [1:0] addr;
        logic [7:0] hdr;
        logic [7:0] x;
        logic [7:0] par;
        logic [7:0] bytes[$];
        logic       pv;
        len  = int'($urandom_range(0, 4));
        addr = 2'($urandom_range(0, 2));
        hdr  = {len[5:0], addr};
        x    = hdr;
        for (int i = 0; i < len; i++) begin
            bytes.push_back(8'($urandom));
            x = x ^ bytes[i];
        end
        par = ($urandom_range(0, 3) == 0) ? (x ^ (8'h01 << $urandom_range(0, 7))) : x;
        bytes.push_back(par);
        abort_at = (allow_abort && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, len)) : -1;
        da(hdr);
        exp_q.push_back(hdr);
        lfd(bytes[0]);
        for (int i = 0; i <= len; i++) begin
            if (i == abort_at) begin
                do_reset();
                idle();
                return;
            end
            pv = (i < len);
            if ($urandom_range(0, 3) != 0) begin
                exp_q.push_back(bytes[i]);
                ldb(bytes[i], pv, 1'b0);
            end else begin
                ldb(bytes[i], pv, 1'b1);
                repeat ($urandom_range(1, 2)) fsc(pv);
                exp_q.push_back(bytes[i]);
                laf(pv);
            end
        end
        idle();
        chk("pkt_parity_done", {7'b0, parity_done}, 8'h01);
        chk("pkt_err", {7'b0, err}, {7'b0, (x != par)});
        rir();
        idle();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        do_reset();
        chk("reset_dout", dout, 8'h00);
        chk("reset_parity_done", {7'b0, parity_done}, 8'h00);
        chk("reset_low_pkt_valid", {7'b0, low_pkt_valid}, 8'h00);
        chk("reset_err", {7'b0, err}, 8'h00);

        // Good packet
        da(8'h0D); lfd(8'hA1);       chk("t1_hdr", dout, 8'h0D);
        ldb(8'hA1, 1, 0);            chk("t1_a1", dout, 8'hA1);
        ldb(8'hB2, 1, 0);            chk("t1_b2", dout, 8'hB2);
        ldb(8'hC3, 1, 0);            chk("t1_c3", dout, 8'hC3);
        ldb(8'hDD, 0, 0);            chk("t1_par", dout, 8'hDD);
        chk("t1_pdone", {7'b0, parity_done}, 8'h01);
        chk("t1_lpv", {7'b0, low_pkt_valid}, 8'h01);
        idle();                      chk("t1_err", {7'b0, err}, 8'h00);
        rir();                       chk("t1_lpv_clr", {7'b0, low_pkt_valid}, 8'h00);

        // Bad parity
        da(8'h0D); lfd(8'hA1); ldb(8'hA1, 1, 0); ldb(8'hB2, 1, 0); ldb(8'hC3, 1, 0);
        ldb(8'hDC, 0, 0);            chk("t2_err_lag", {7'b0, err}, 8'h00);
        idle();                      chk("t2_err", {7'b0, err}, 8'h01);
        rir();

        // FIFO full mid-payload
        da(8'h0D);                   chk("t3_err_clr", {7'b0, err}, 8'h00);
        chk("t3_pdone_clr", {7'b0, parity_done}, 8'h00);
        lfd(8'hA1); ldb(8'hA1, 1, 0);
        ldb(8'hB2, 1, 1);            chk("t3_hold1", dout, 8'hA1);
        fsc(1);                      chk("t3_hold2", dout, 8'hA1);
        laf(1);                      chk("t3_replay", dout, 8'hB2);
        ldb(8'hC3, 1, 0);            chk("t3_c3", dout, 8'hC3);
        ldb(8'hDD, 0, 0); idle();    chk("t3_err", {7'b0, err}, 8'h00);
        rir();

        // Parity byte arrives while full
        da(8'h0D); lfd(8'hA1); ldb(8'hA1, 1, 0); ldb(8'hB2, 1, 0); ldb(8'hC3, 1, 0);
        ldb(8'hDD, 0, 1);            chk("t4_lpv", {7'b0, low_pkt_valid}, 8'h01);
        chk("t4_pdone_wait", {7'b0, parity_done}, 8'h00);
        chk("t4_hold", dout, 8'hC3);
        fsc(0);
        laf(0);                      chk("t4_pdone", {7'b0, parity_done}, 8'h01);
        chk("t4_replay", dout, 8'hDD);
        idle();                      chk("t4_err", {7'b0, err}, 8'h00);
        rir();                       chk("t4_lpv_clr", {7'b0, low_pkt_valid}, 8'h00);

        // Zero-length payload: header parity only
        da(8'h01); lfd(8'h01); ldb(8'h01, 0, 0);
        idle();                      chk("zl_err", {7'b0, err}, 8'h00);
        rir();

        // Reset mid-packet, then a clean packet
        da(8'h0D); lfd(8'hA1); ldb(8'hA1, 1, 0);
        do_reset();                  chk("t5_dout", dout, 8'h00);
        chk("t5_pdone", {7'b0, parity_done}, 8'h00);
        chk("t5_lpv", {7'b0, low_pkt_valid}, 8'h00);
        chk("t5_err", {7'b0, err}, 8'h00);
        da(8'h05); lfd(8'h7E); ldb(8'h7E, 1, 0); ldb(8'h7B, 0, 0);
        idle();                      chk("t5_pkt_err", {7'b0, err}, 8'h00);

        // Simultaneous events
        drive(0, 1, 0, 1, 0, 0, 0, 0, 0, 8'h7B);
        chk("t6_pdone_set_wins", {7'b0, parity_done}, 8'h01);
        drive(0, 0, 0, 1, 0, 0, 1, 0, 0, 8'h7B);
        chk("t6_lpv_set_wins", {7'b0, low_pkt_valid}, 8'h01);
        do_reset();

        // Randomized packets
        repeat (80) rand_pkt(1'b1);

        idle();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_router_reg
`default_nettype wire

// File: doc/router_reg.md
Name: router_reg

Overview:
- Datapath register stage of the 1x3 router.
- Sits directly downstream of fsm_controller: consumes its state strobes (detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg).
- Latches the header byte, holds the byte that arrives while the FIFO is full, and drives the byte stream dout to the FIFOs.
- Accumulates running XOR parity and flags a parity error. Produces parity_done and low_pkt_valid, which feed back into fsm_controller.

Parameters:
DATA_WIDTH, 8, width of packet bytes (header, payload, parity)

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous reset, active-high
pkt_valid  input  1  source asserts while header/payload bytes are valid; deasserts on the parity byte
data_in  input  DATA_WIDTH  packet byte from source
fifo_full  input  1  selected destination FIFO is full
detect_addr  input  1  FSM in DECODE_ADDRESS
lfd_state  input  1  FSM in LOAD_FIRST_DATA
ld_state  input  1  FSM in LOAD_DATA
laf_state  input  1  FSM in LOAD_AFTER_FULL
full_state  input  1  FSM in FIFO_FULL_STATE
rst_int_reg  input  1  FSM in CHECK_PARITY_ERROR; clears low_pkt_valid
parity_done  output  1  packet parity byte has been captured
low_pkt_valid  output  1  pkt_valid fell while loading data
err  output  1  computed parity differs from packet parity
dout  output  DATA_WIDTH  byte written to destination FIFO

Behaviour:
- Reset: all outputs 0. Internal registers header_byte, full_byte, int_parity and pkt_parity are also 0. rst has priority over every other condition.
- header_byte:
  - Loaded with data_in when detect_addr && pkt_valid.
  - Otherwise holds.
- full_byte:
  - Loaded with data_in when ld_state && fifo_full. This is the byte that arrived in the same cycle the FIFO filled.
  - Otherwise holds.
- dout, registered with 1-cycle latency, priority in this order:
  1. lfd_state: dout <= header_byte.
  2. ld_state && !fifo_full: dout <= data_in.
  3. laf_state: dout <= full_byte.
  4. Otherwise: hold.
- int_parity:
  - Cleared on detect_addr.
  - lfd_state: int_parity <= int_parity ^ header_byte.
  - ld_state && pkt_valid && !full_state: int_parity <= int_parity ^ data_in.
  - Otherwise holds. The parity byte itself is never folded in.
- pkt_parity:
  - Loaded with data_in when ld_state && !pkt_valid && !fifo_full.
  - Loaded with full_byte when laf_state && low_pkt_valid && !parity_done.
  - Cleared on detect_addr.
- low_pkt_valid:
  - Set when ld_state && !pkt_valid.
  - Cleared when rst_int_reg.
  - Set wins if both occur in the same cycle.
- parity_done:
  - Set when (ld_state && !fifo_full && !pkt_valid) || (laf_state && low_pkt_valid && !parity_done).
  - Cleared on detect_addr. Set wins over clear.
  - Once set, stays 1 until the next detect_addr or rst.
- err:
  - Evaluated every cycle parity_done == 1: err <= (int_parity != pkt_parity). This makes err valid 1 cycle after parity_done rises.
  - Cleared on detect_addr or rst.
  - Held when parity_done == 0.
- Boundaries:
  - fifo_full during ld_state: dout does not update. The byte is captured in full_byte and replayed in laf_state.
  - pkt_valid low on the same edge as fifo_full: the parity byte goes through full_byte, and parity_done sets in laf_state.
  - Zero-length payload: header parity only.
  - Mid-packet rst: all state cleared; the next packet starts clean on detect_addr.
  - Width: all parity is a bitwise XOR of DATA_WIDTH bits; no carries.

Decomposition:
- Shared package router_pkg holds:
  - DATA_WIDTH default
  - address field encoding (data_in[1:0]: 00/01/10 select FIFO 0/1/2; 11 invalid)
  - the FSM state encodings already used by fsm_controller, for use by testbench decoders
- One natural sub-module, router_parity_chk:
  - contains int_parity, pkt_parity and err
  - inputs: strobes, data_in, header_byte, full_byte
  - output: err
- The top level keeps header_byte, full_byte, dout, low_pkt_valid and parity_done.

Test Plan:
1. Good packet. Stimulus: header 8'h0D (len 3, addr 01), payload A1,B2,C3, parity DD, strobes sequenced DA->LFD->LD. Required: dout = 0D,A1,B2,C3,DD; parity_done = 1 after the DD cycle; err = 0.
2. Bad parity. Same packet with parity 8'hDC. Required: err = 1 one cycle after parity_done; err cleared on the next detect_addr.
3. FIFO full mid-payload. fifo_full = 1 with ld_state while data_in = B2, then full_state, then laf_state. Required: dout holds A1 during full; B2 emitted in laf_state; final err = 0.
4. Parity byte arrives while full. pkt_valid falls with fifo_full = 1 on byte DD. Required: low_pkt_valid = 1; parity_done sets in laf_state; dout = DD; err = 0; rst_int_reg then clears low_pkt_valid.
5. Reset mid-packet. rst = 1 after byte A1. Required: dout, parity_done, low_pkt_valid and err all 0 next cycle; the next packet (header 8'h05, payload 7E, parity 7B) yields err = 0.
6. Simultaneous events: detect_addr and parity_done set condition in the same cycle. Required: parity_done = 1 (set wins); rst_int_reg with ld_state && !pkt_valid leaves low_pkt_valid = 1.
